// File: rtl/sparc_ifu_thrpick_pkg.sv
// Shared IFU thread-switch codes: thread FSM state encodings, picker states, helpers.
// Used by the picker top, its arbiter and the per-thread FSMs.
package sparc_ifu_thrpick_pkg;

  localparam int unsigned THR_N  = 4;
  localparam int unsigned THR_SW = 5;

  typedef enum logic [4:0] {
    THR_IDLE     = 5'b00000,
    THR_WAIT     = 5'b00001,
    THR_HALT     = 5'b00010,
    THR_RUN      = 5'b00101,
    THR_SPEC_RUN = 5'b00111,
    THR_SPEC_RDY = 5'b10011,
    THR_RDY      = 5'b11001
  } thr_state_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_ACK  = 2'd1,
    P_RUN  = 2'd2,
    P_SWO  = 2'd3
  } pick_state_e;

  function automatic logic thr_is_ready(input logic [4:0] s);
    return s == THR_RDY;
  endfunction

  function automatic logic thr_is_spec(input logic [4:0] s);
    return s == THR_SPEC_RDY;
  endfunction

  function automatic logic thr_is_running(input logic [4:0] s);
    return (s == THR_RUN) || (s == THR_SPEC_RUN);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sparc_ifu_thrpick_if.sv
// Picker <-> thread FSM / fetch control signal bundle.
// master = picker side, slave = thread FSMs and fetch control.
interface sparc_ifu_thrpick_if;
  logic [19:0] thr_state;
  logic        fcl_swl_swout_req;
  logic        pick_hold;
  logic [3:0]  schedule;
  logic        switch_out;
  logic [3:0]  run_thr;

  modport master (
    input  thr_state, fcl_swl_swout_req, pick_hold,
    output schedule, switch_out, run_thr
  );

  modport slave (
    output thr_state, fcl_swl_swout_req, pick_hold,
    input  schedule, switch_out, run_thr
  );
endinterface

// File: rtl/sparc_ifu_rrarb.sv
// Combinational 4-way round-robin arbiter; search starts at ptr+1 and wraps,
// so ptr itself is the last candidate and a lone requester always wins.
module sparc_ifu_rrarb (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;

  always_comb begin
    gnt = '0;
    idx = ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sparc_ifu_thrpick.sv
// IFU thread picker / switch controller. Optional time-slice forced switch is
// built when IFU_THRPICK_TIMESLICE_EN is defined.
module sparc_ifu_thrpick
  import sparc_ifu_thrpick_pkg::*;
#(
  parameter int unsigned NUM_THR = 4
`ifdef IFU_THRPICK_TIMESLICE_EN
  , parameter int unsigned TSLICE_W = 6
  , parameter logic [TSLICE_W-1:0] TSLICE = TSLICE_W'(32)
`endif
) (
  input logic                 clk,
  input logic                 reset,
  sparc_ifu_thrpick_if.master ifu
);

  logic [NUM_THR-1:0] ready_v;
  logic [NUM_THR-1:0] spec_v;
  logic [NUM_THR-1:0] run_v;
  logic [3:0]         rdy_gnt;
  logic [3:0]         spec_gnt;
  logic [3:0]         win;
  logic               any_elig;
  logic               other_elig;
  logic               running_cur;
  logic               swout_cond;

  pick_state_e state, state_nxt;
  logic [3:0]  run_thr_q, run_thr_nxt;
  logic [1:0]  rr_ptr, rr_ptr_nxt;
  logic [3:0]  sched;
  logic        swo;

  for (genvar i = 0; i < NUM_THR; i++) begin : g_thr
    logic [4:0] st;
    assign st         = ifu.thr_state[5*i +: 5];
    assign ready_v[i] = thr_is_ready(st);
    assign spec_v[i]  = thr_is_spec(st);
    assign run_v[i]   = thr_is_running(st);
  end

  sparc_ifu_rrarb u_rdy_arb (
    .req (ready_v),
    .ptr (rr_ptr),
    .gnt (rdy_gnt)
  );

  sparc_ifu_rrarb u_spec_arb (
    .req (spec_v),
    .ptr (rr_ptr),
    .gnt (spec_gnt)
  );

  // Ready class strictly outranks speculative class.
  assign win         = (rdy_gnt != '0) ? rdy_gnt : spec_gnt;
  assign any_elig    = |(ready_v | spec_v);
  assign other_elig  = |((ready_v | spec_v) & ~run_thr_q);
  assign running_cur = |(run_v & run_thr_q);

`ifdef IFU_THRPICK_TIMESLICE_EN
  logic [TSLICE_W-1:0] slice_cnt;
  logic                slice_exp;

  // Cleared in the ack cycle, which always precedes the first P_RUN cycle.
  always_ff @(posedge clk) begin
    if (reset || (state == P_ACK)) begin
      slice_cnt <= '0;
    end else if ((state == P_RUN) && (slice_cnt != TSLICE)) begin
      slice_cnt <= slice_cnt + 1'b1;
    end
  end

  assign slice_exp  = (slice_cnt == TSLICE);
  assign swout_cond = ifu.fcl_swl_swout_req | slice_exp;
`else
  assign swout_cond = ifu.fcl_swl_swout_req;
`endif

  always_comb begin
    state_nxt   = state;
    run_thr_nxt = run_thr_q;
    rr_ptr_nxt  = rr_ptr;
    sched       = '0;
    swo         = 1'b0;
    unique case (state)
      P_IDLE: begin
        if (!ifu.pick_hold && any_elig) begin
          sched       = win;
          run_thr_nxt = win;
          rr_ptr_nxt  = onehot_idx(win);
          state_nxt   = P_ACK;
        end
      end
      P_ACK: begin
        // A thread that stalls in its ack cycle never ran: drop it quietly.
        if (running_cur) begin
          state_nxt = P_RUN;
        end else begin
          run_thr_nxt = '0;
          state_nxt   = P_IDLE;
        end
      end
      P_RUN: begin
        if (!running_cur) begin
          run_thr_nxt = '0;
          state_nxt   = P_IDLE;
        end else if (swout_cond && other_elig) begin
          swo       = 1'b1;
          state_nxt = P_SWO;
        end
      end
      P_SWO: begin
        run_thr_nxt = '0;
        state_nxt   = P_IDLE;
      end
      default: begin
        run_thr_nxt = '0;
        state_nxt   = P_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= P_IDLE;
      run_thr_q <= '0;
      rr_ptr    <= 2'd3;
    end else begin
      state     <= state_nxt;
      run_thr_q <= run_thr_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  // Pulses are Mealy outputs; gate them so a reset cycle never leaks one.
  assign ifu.schedule   = reset ? '0 : sched;
  assign ifu.switch_out = ~reset & swo;
  assign ifu.run_thr    = run_thr_q;

  a_pulse_excl : assert property (@(posedge clk) disable iff (reset)
    !((ifu.schedule != '0) && ifu.switch_out));
  a_sched_onehot : assert property (@(posedge clk) $onehot0(ifu.schedule));

endmodule

// File: tb/tb_sparc_ifu_thrpick.sv
// Self-checking bench for sparc_ifu_thrpick: directed scenarios plus randomized
// thread-state traffic, checked against a cycle-level ownership model.
module tb_sparc_ifu_thrpick;

  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_WAIT = 5'b00001;
  localparam logic [4:0] C_RUN  = 5'b00101;
  localparam logic [4:0] C_SRUN = 5'b00111;
  localparam logic [4:0] C_SRDY = 5'b10011;
  localparam logic [4:0] C_RDY  = 5'b11001;

`ifdef IFU_THRPICK_TIMESLICE_EN
  localparam int SLICE_LIM = 32;
`else
  localparam int SLICE_LIM = -1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sparc_ifu_thrpick_if ifu ();

  sparc_ifu_thrpick dut (
    .clk   (clk),
    .reset (reset),
    .ifu   (ifu)
  );

  logic [4:0] ts [4];
  logic       req, hold;
  bit         stall, drift;

  assign ifu.thr_state         = {ts[3], ts[2], ts[1], ts[0]};
  assign ifu.fcl_swl_swout_req = req;
  assign ifu.pick_hold         = hold;

  // Model: which thread the picker owns and what it is doing with it.
  int owner, rr, slice;
  bit confirming, releasing;
  int n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_rdy(input logic [4:0] s);  return s == C_RDY;  endfunction
  function automatic bit is_srdy(input logic [4:0] s); return s == C_SRDY; endfunction
  function automatic bit is_run(input logic [4:0] s);  return (s == C_RUN) || (s == C_SRUN); endfunction

  function automatic int pick_from(input int base, input bit want_ready);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (base + k) % 4;
      if (want_ready ? is_rdy(ts[j]) : is_srdy(ts[j])) return j;
    end
    return -1;
  endfunction

  function automatic bit others_eligible(input int o);
    for (int j = 0; j < 4; j++)
      if (j != o && (is_rdy(ts[j]) || is_srdy(ts[j]))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    owner = -1; rr = 3; slice = 0; confirming = 0; releasing = 0;
  endtask

  task automatic drift_threads(input int skip_a, input int skip_b);
    for (int j = 0; j < 4; j++) begin
      if (j != skip_a && j != skip_b) begin
        int r;
        r = $urandom_range(0, 99);
        case (ts[j])
          C_RUN, C_SRUN: if (r < 5) ts[j] = C_WAIT;
          C_WAIT:        if (r < 25) ts[j] = (r < 12) ? C_RDY : C_SRDY;
          C_IDLE:        if (r < 10) ts[j] = C_RDY; else if (r < 13) ts[j] = C_SRDY;
          C_RDY, C_SRDY: if (r < 3) ts[j] = C_IDLE;
          default:       if (r < 50) ts[j] = C_IDLE;
        endcase
        if (r == 99) ts[j] = 5'($urandom);
      end
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance model
  // and the emulated thread FSMs after the edge. want[4]=0 adds a fixed check.
  task automatic step(input string tag, input logic [4:0] want = 5'h10);
    logic [3:0] es, er;
    bit eo;
    int w, n_owner, n_rr, n_slice, old_owner;
    bit n_conf, n_rel;
    @(negedge clk);
    es = '0; eo = 0; w = -1;
    er = (owner < 0) ? 4'b0 : 4'(1 << owner);
    n_owner = owner; n_rr = rr; n_slice = slice; n_conf = confirming; n_rel = releasing;
    old_owner = owner;
    if (owner < 0) begin
      if (!hold) begin
        w = pick_from(rr, 1'b1);
        if (w < 0) w = pick_from(rr, 1'b0);
        if (w >= 0) begin
          es = 4'(1 << w); n_owner = w; n_conf = 1; n_rr = w;
        end
      end
    end else if (confirming) begin
      n_conf = 0;
      if (is_run(ts[owner])) n_slice = 0; else n_owner = -1;
    end else if (releasing) begin
      n_rel = 0; n_owner = -1;
    end else if (!is_run(ts[owner])) begin
      n_owner = -1;
    end else begin
      if ((req || slice == SLICE_LIM) && others_eligible(owner)) begin
        eo = 1; n_rel = 1;
      end
      if (SLICE_LIM > 0 && slice != SLICE_LIM) n_slice = slice + 1;
    end
    if (reset) begin es = '0; eo = 0; end
    check({tag, "_sched"}, 32'(ifu.schedule), 32'(es));
    check({tag, "_swout"}, 32'(ifu.switch_out), 32'(eo));
    check({tag, "_runthr"}, 32'(ifu.run_thr), 32'(er));
    if (!want[4]) check({tag, "_fixed"}, 32'(ifu.schedule), 32'(want[3:0]));
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      owner = n_owner; rr = n_rr; slice = n_slice; confirming = n_conf; releasing = n_rel;
      if (w >= 0) ts[w] = stall ? C_WAIT : (is_rdy(ts[w]) ? C_RUN : C_SRUN);
      if (eo) ts[old_owner] = (ts[old_owner] == C_SRUN) ? C_SRDY : C_RDY;
      if (drift) drift_threads(w, eo ? old_owner : -1);
    end
  endtask

  task automatic do_reset(input logic [4:0] t0, input logic [4:0] t1,
                          input logic [4:0] t2, input logic [4:0] t3);
    reset = 1'b1; req = 1'b0; hold = 1'b0; stall = 0;
    ts[0] = t0; ts[1] = t1; ts[2] = t2; ts[3] = t3;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step("rst");
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; drift = 0;
    model_reset();

    // 1: T0/T2 ready -> T0 first; after T0 waits, T2 next.
    do_reset(C_RDY, C_IDLE, C_RDY, C_IDLE);
    step("t1_pick0", 5'b00001);
    step("t1_ack");
    step("t1_run");
    ts[0] = C_WAIT;
    step("t1_leave");
    step("t1_pick2", 5'b00100);
    step("t1_ack2");

    // 2: T1 running, T3 ready, switch-out request.
    do_reset(C_IDLE, C_RDY, C_IDLE, C_IDLE);
    step("t2_pick1", 5'b00010);
    step("t2_ack");
    ts[3] = C_RDY; req = 1'b1;
    step("t2_swo");
    req = 1'b0;
    step("t2_swoidle", 5'b00000);
    step("t2_pick3", 5'b01000);

    // 3: ready beats speculative.
    do_reset(C_SRDY, C_RDY, C_IDLE, C_IDLE);
    step("t3_pick", 5'b00010);
    step("t3_ack");

    // 4: scheduled thread stalls in ack cycle -> drop, re-pick next cycle.
    do_reset(C_IDLE, C_IDLE, C_RDY, C_IDLE);
    stall = 1;
    step("t4_pick", 5'b00100);
    stall = 0;
    ts[0] = C_RDY;
    step("t4_ack");
    step("t4_repick", 5'b00001);
    step("t4_ack2");

    // 5: long run with another thread ready and no request.
    do_reset(C_RDY, C_IDLE, C_IDLE, C_IDLE);
    step("t5_pick", 5'b00001);
    step("t5_ack");
    ts[1] = C_RDY;
    for (int i = 0; i < 40; i++) step("t5_slice");

    // 6: reset in ack cycle, reset in switch-out cycle, pick_hold.
    do_reset(C_RDY, C_IDLE, C_IDLE, C_IDLE);
    step("t6_pick", 5'b00001);
    reset = 1'b1;
    step("t6_rst_ack");
    step("t6_rst_after", 5'b00000);
    reset = 1'b0;
    step("t6_pick_b");
    step("t6_ack_b");
    ts[1] = C_RDY; ts[2] = C_RDY; req = 1'b1;
    step("t6_swo");
    req = 1'b0; reset = 1'b1;
    step("t6_rst_swo");
    step("t6_rst_after2", 5'b00000);
    reset = 1'b0; hold = 1'b1;
    for (int i = 0; i < 4; i++) step("t6_hold", 5'b00000);
    hold = 1'b0;
    step("t6_unhold");

    // Randomized traffic.
    do_reset(C_RDY, C_IDLE, C_SRDY, C_WAIT);
    drift = 1;
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      if (i % 700 == 699) reset = 1'b1;
      step("rand");
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
